// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants and state type for the instruction-fetch stage
package ifetch_pkg;
  localparam logic [31:0] ECALL_INSN  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
  localparam logic [31:0] A7_READ_INT = 32'd5;
  localparam logic [31:0] A7_EXIT     = 32'd10;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  typedef enum logic [1:0] {RUN, WAIT_IN, HALT} state_t;
endpackage

// File: rtl/ifetch_ctrl_if.sv
// ifetch_ctrl_if: instruction-memory bus between fetch stage (master) and ROM (slave)
interface ifetch_ctrl_if #(parameter int IMEM_AW = 14);
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_data;
  modport master(output imem_addr, input imem_data);
  modport slave(input imem_addr, output imem_data);
endinterface

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: synchronises a raw button and emits a one-cycle rising-edge pulse
module btn_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);
  logic [STAGES-1:0] sync;
  logic              prev;
  assign rise = sync[STAGES-1] & ~prev;
  // shift the raw button through the chain and keep the last synchronised value
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= STAGES'({sync, btn});
      prev <= sync[STAGES-1];
    end
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: PC / next-PC / ecall stall control; IFETCH_EBREAK_PAUSE_EN makes ebreak pause
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE   = RESET_PC,
  parameter int          IMEM_AW     = 14,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  ifetch_ctrl_if.master        imem,
  output logic [31:0]          instruction,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  input  logic [31:0]          imm32,
  input  logic [31:0]          alu_result,
  input  logic                 branch,
  input  logic                 branch_taken,
  input  logic                 jal,
  input  logic                 jalr,
  input  logic [31:0]          a7,
  input  logic                 confirm_btn,
  output logic                 stall,
  output logic                 in_accept,
  output logic                 halted,
  output logic                 misalign
);
  state_t      state;
  logic        btn_rise;
  logic        is_ecall;
  logic        is_ebreak;
  logic        pause_src;
  logic [31:0] target;

  btn_sync_edge #(.STAGES(SYNC_STAGES)) u_btn (
    .clk   (clk),
    .reset (reset),
    .btn   (confirm_btn),
    .rise  (btn_rise)
  );

  assign instruction    = imem.imem_data;
  assign imem.imem_addr = pc[IMEM_AW+1:2];
  assign pc_plus4       = pc + 32'd4;
  assign is_ecall       = instruction == ECALL_INSN;
  assign target         = jalr ? (alu_result & ~32'h1)
                        : (jal || (branch && branch_taken)) ? pc + imm32 : pc_plus4;
  assign in_accept      = (state == WAIT_IN) && btn_rise && !pause_src;

`ifdef IFETCH_EBREAK_PAUSE_EN
  assign is_ebreak = instruction == EBREAK_INSN;
  // while running, track whether a pause about to start comes from ebreak
  always_ff @(posedge clk or negedge reset)
    if (!reset) pause_src <= 1'b0;
    else if (state == RUN) pause_src <= is_ebreak;
`else
  assign is_ebreak = 1'b0;
  assign pause_src = 1'b0;
`endif

  // fetch FSM: pc update, ecall/ebreak pauses, exit and misalignment halts
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= RUN;
      pc       <= TEXT_BASE;
      stall    <= 1'b0;
      halted   <= 1'b0;
      misalign <= 1'b0;
    end else begin
      case (state)
        RUN:
          if ((is_ecall && a7 == A7_READ_INT) || is_ebreak) begin
            state <= WAIT_IN;
            stall <= 1'b1;
          end else if (is_ecall && a7 == A7_EXIT) begin
            state  <= HALT;
            stall  <= 1'b1;
            halted <= 1'b1;
          end else if (is_ecall) begin
            pc <= pc_plus4;
          end else if (target[1:0] != 2'b00) begin
            state    <= HALT;
            stall    <= 1'b1;
            halted   <= 1'b1;
            misalign <= 1'b1;
          end else begin
            pc <= target;
          end
        WAIT_IN:
          if (btn_rise) begin
            state <= RUN;
            stall <= 1'b0;
            pc    <= pc_plus4;
          end
        HALT: ;
        default: begin
          state  <= HALT;
          stall  <= 1'b1;
          halted <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed and randomized checks of ifetch_ctrl against a behavioural model
module tb_ifetch_ctrl;
  localparam int          SYNC   = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction, pc, pc_plus4, imm32, alu_result, a7;
  logic        branch, branch_taken, jal, jalr, confirm_btn;
  logic        stall, in_accept, halted, misalign;
  logic [31:0] rom [16384];

  int checks = 0;
  int failures = 0;

  logic [31:0] m_pc;
  bit          m_wait, m_halt, m_mis, m_ebrk;
  bit          bq[$];
  bit          acc_seen;

  ifetch_ctrl_if #(.IMEM_AW(14)) imem_bus();
  assign imem_bus.imem_data = rom[imem_bus.imem_addr];

  ifetch_ctrl #(.TEXT_BASE(32'h0), .IMEM_AW(14), .SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem         (imem_bus),
    .instruction  (instruction),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .imm32        (imm32),
    .alu_result   (alu_result),
    .branch       (branch),
    .branch_taken (branch_taken),
    .jal          (jal),
    .jalr         (jalr),
    .a7           (a7),
    .confirm_btn  (confirm_btn),
    .stall        (stall),
    .in_accept    (in_accept),
    .halted       (halted),
    .misalign     (misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_pc = 32'h0; m_wait = 0; m_halt = 0; m_mis = 0; m_ebrk = 0;
    bq = {};
    repeat (SYNC + 1) bq.push_back(1'b0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    model_reset();
  endtask

  task automatic clear_ctrl();
    branch = 0; branch_taken = 0; jal = 0; jalr = 0; imm32 = 0; alu_result = 0;
  endtask

  // one clock: check combinational outputs, advance the model, check registered outputs
  task automatic step();
    logic [31:0] ins, tgt;
    bit rise, exp_acc;
    #1;
    rise    = bq[1] && !bq[0];
    exp_acc = m_wait && rise && !m_ebrk;
    ins     = rom[m_pc[15:2]];
    checks++;
    if (in_accept !== exp_acc) begin failures++; $display("FAIL in_accept pc=%h got %b expected %b", m_pc, in_accept, exp_acc); end
    checks++;
    if (instruction !== ins) begin failures++; $display("FAIL instruction got %h expected %h", instruction, ins); end
    checks++;
    if (pc_plus4 !== m_pc + 32'd4) begin failures++; $display("FAIL pc_plus4 got %h expected %h", pc_plus4, m_pc + 32'd4); end
    acc_seen = in_accept;
    if (m_halt) begin
    end else if (m_wait) begin
      if (rise) begin m_wait = 0; m_pc = m_pc + 4; end
    end else if (ins == ECALL && a7 == 5) begin
      m_wait = 1; m_ebrk = 0;
    end else if (ins == ECALL && a7 == 10) begin
      m_halt = 1;
    end else if (ins == ECALL) begin
      m_pc = m_pc + 4;
`ifdef IFETCH_EBREAK_PAUSE_EN
    end else if (ins == EBREAK) begin
      m_wait = 1; m_ebrk = 1;
`endif
    end else begin
      if (jalr) tgt = {alu_result[31:1], 1'b0};
      else if (jal) tgt = m_pc + imm32;
      else if (branch && branch_taken) tgt = m_pc + imm32;
      else tgt = m_pc + 4;
      if (tgt % 4 != 0) begin m_mis = 1; m_halt = 1; end
      else m_pc = tgt;
    end
    @(posedge clk);
    bq.push_back(confirm_btn);
    void'(bq.pop_front());
    #1;
    checks++;
    if (pc !== m_pc) begin failures++; $display("FAIL pc got %h expected %h", pc, m_pc); end
    checks++;
    if (stall !== (m_wait || m_halt)) begin failures++; $display("FAIL stall got %b expected %b", stall, m_wait || m_halt); end
    checks++;
    if (halted !== m_halt) begin failures++; $display("FAIL halted got %b expected %b", halted, m_halt); end
    checks++;
    if (misalign !== m_mis) begin failures++; $display("FAIL misalign got %b expected %b", misalign, m_mis); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got %h expected 0", pc); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got %b expected 0", stall); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got %b expected 0", halted); end
    checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got %b expected 0", misalign); end
    checks++; if (in_accept !== 1'b0) begin failures++; $display("FAIL reset_in_accept got %b expected 0", in_accept); end
    apply_reset();
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (pc !== 32'(i * 4)) begin failures++; $display("FAIL seq_pc got %h expected %h", pc, i * 4); end
    end
  endtask

  task automatic test_branch();
    branch = 1; branch_taken = 1; imm32 = 32'hFFFF_FFF8;
    step();
    checks++; if (pc !== 32'h08) begin failures++; $display("FAIL beq_taken got %h expected 08", pc); end
    clear_ctrl();
    step(); step();
    branch = 1; branch_taken = 0; imm32 = 32'hFFFF_FFF8;
    step();
    checks++; if (pc !== 32'h14) begin failures++; $display("FAIL beq_not_taken got %h expected 14", pc); end
    clear_ctrl();
  endtask

  task automatic test_jump_misalign();
    jalr = 1; alu_result = 32'h25;
    step();
    checks++; if (pc !== 32'h24) begin failures++; $display("FAIL jalr_target got %h expected 24", pc); end
    clear_ctrl();
    jal = 1; imm32 = 32'h6;
    step();
    checks++; if (misalign !== 1'b1 || halted !== 1'b1) begin failures++; $display("FAIL jal_misalign got mis=%b halt=%b expected 1 1", misalign, halted); end
    clear_ctrl();
    step(); step();
    checks++; if (pc !== 32'h24) begin failures++; $display("FAIL misalign_pc_hold got %h expected 24", pc); end
  endtask

  task automatic test_ecall_read();
    int n, acc;
    apply_reset();
    rom[12] = ECALL; a7 = 5; confirm_btn = 1;
    repeat (12) step();
    checks++; if (pc !== 32'h30 || stall !== 1'b0) begin failures++; $display("FAIL reach_30 got pc=%h stall=%b expected 30 0", pc, stall); end
    step();
    repeat (4) step();
    checks++; if (stall !== 1'b1 || pc !== 32'h30) begin failures++; $display("FAIL held_btn got stall=%b pc=%h expected 1 30", stall, pc); end
    confirm_btn = 0;
    repeat (4) step();
    confirm_btn = 1;
    n = 0; acc = 0;
    while (pc == 32'h30 && n < 10) begin
      step(); n++; acc += int'(acc_seen);
    end
    checks++; if (n != SYNC + 1) begin failures++; $display("FAIL press_latency got %0d expected %0d", n, SYNC + 1); end
    checks++; if (pc !== 32'h34) begin failures++; $display("FAIL ecall_resume_pc got %h expected 34", pc); end
    checks++; if (acc != 1) begin failures++; $display("FAIL accept_pulses got %0d expected 1", acc); end
    confirm_btn = 0; a7 = 0;
  endtask

  task automatic test_exit();
    rom[16] = ECALL; a7 = 10;
    repeat (4) step();
    checks++; if (halted !== 1'b1 || pc !== 32'h40) begin failures++; $display("FAIL exit_halt got halt=%b pc=%h expected 1 40", halted, pc); end
    repeat (5) step();
    checks++; if (halted !== 1'b1 || stall !== 1'b1 || pc !== 32'h40) begin failures++; $display("FAIL exit_stays got halt=%b stall=%b pc=%h", halted, stall, pc); end
    #2 reset = 1'b0;
    #1;
    checks++; if (pc !== 32'h0 || halted !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL async_reset got pc=%h halt=%b stall=%b expected 0 0 0", pc, halted, stall); end
    @(posedge clk);
    #3 reset = 1'b1;
    model_reset();
    a7 = 0;
    step();
    checks++; if (pc !== 32'h4) begin failures++; $display("FAIL after_reset_pc got %h expected 4", pc); end
  endtask

  task automatic test_ebreak();
    int n, acc;
    rom[20] = EBREAK; confirm_btn = 0;
    repeat (19) step();
    checks++; if (pc !== 32'h50) begin failures++; $display("FAIL reach_50 got %h expected 50", pc); end
    step();
`ifdef IFETCH_EBREAK_PAUSE_EN
    checks++; if (stall !== 1'b1 || pc !== 32'h50) begin failures++; $display("FAIL ebreak_pause got stall=%b pc=%h expected 1 50", stall, pc); end
    confirm_btn = 1;
    n = 0; acc = 0;
    while (pc == 32'h50 && n < 10) begin
      step(); n++; acc += int'(acc_seen);
    end
    checks++; if (pc !== 32'h54 || acc != 0) begin failures++; $display("FAIL ebreak_resume got pc=%h accepts=%0d expected 54 0", pc, acc); end
    confirm_btn = 0;
`else
    n = 0; acc = 0;
    checks++; if (pc !== 32'h54 || stall !== 1'b0) begin failures++; $display("FAIL ebreak_nop got pc=%h stall=%b expected 54 0", pc, stall); end
`endif
  endtask

  task automatic test_random();
    int hold;
    for (int i = 0; i < 256; i++) begin
      int r = $urandom_range(0, 15);
      rom[i] = (r == 0) ? ECALL : (r == 1) ? EBREAK : NOP;
    end
    apply_reset();
    hold = 0;
    repeat (600) begin
      int s = $urandom_range(0, 15);
      clear_ctrl();
      jalr = (s == 0);
      jal = (s == 1);
      branch = (s >= 2 && s <= 5);
      branch_taken = 1'($urandom_range(0, 1));
      imm32 = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'(($urandom_range(0, 63) - 32) * 4);
      alu_result = 32'($urandom_range(0, 1023));
      s = $urandom_range(0, 15);
      a7 = (s < 5) ? 32'd5 : (s == 5) ? 32'd10 : 32'($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) confirm_btn = ~confirm_btn;
      step();
      hold = m_halt ? hold + 1 : 0;
      if (hold > 2) begin apply_reset(); hold = 0; end
    end
    clear_ctrl();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) rom[i] = NOP;
    clear_ctrl();
    a7 = 0; confirm_btn = 0; reset = 1'b1;
    model_reset();
    test_reset();
    test_sequential();
    test_branch();
    test_jump_misalign();
    test_ecall_read();
    test_exit();
    test_ebreak();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
